// File: rtl/laser_sample_avg_if.sv
// Bundle of laser-level inputs, shared ADC sample bus and per-channel averaging results.
// The sequencer/bench side drives through master; the averager sits on slave.
interface laser_sample_avg_if #(
  parameter int ADC_WIDTH = 8
);
  logic                 red_laser;
  logic                 IR_laser;
  logic [ADC_WIDTH-1:0] adc_data;
  logic [ADC_WIDTH-1:0] red_avg;
  logic [ADC_WIDTH-1:0] ir_avg;
  logic                 red_valid;
  logic                 ir_valid;
  logic                 pair_valid;
  logic                 err_short;
  logic                 err_both;

  modport master (
    output red_laser, IR_laser, adc_data,
    input  red_avg, ir_avg, red_valid, ir_valid, pair_valid, err_short, err_both
  );

  modport slave (
    input  red_laser, IR_laser, adc_data,
    output red_avg, ir_avg, red_valid, ir_valid, pair_valid, err_short, err_both
  );
endinterface

// File: rtl/laser_sample_avg.sv
// Per laser on-window: skip settle strobes, average 2^AVG_LOG2 ADC samples and publish
// the channel mean, pairing fresh red/IR results for the downstream SpO2 ratio stage.
module laser_sample_avg #(
  parameter int ADC_WIDTH      = 8,
  parameter int SAMPLE_DIV     = 50_000,
  parameter int SETTLE_SAMPLES = 16,
  parameter int AVG_LOG2       = 6
) (
  input  logic              clk,
  input  logic              rst,
  laser_sample_avg_if.slave bus
);

  localparam int DIV_W       = $clog2(SAMPLE_DIV);
  localparam int SET_W       = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam int SAMP_W      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W       = ADC_WIDTH + AVG_LOG2;
  localparam int SETTLE_LAST = (SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0;
  localparam int SAMP_LAST   = (1 << AVG_LOG2) - 1;

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, HOLD} state_t;

  state_t             state;
  logic               chan_ir;      // 0: red window, 1: IR window
  logic [DIV_W-1:0]   div_cnt;
  logic [SET_W-1:0]   settle_cnt;
  logic [SAMP_W-1:0]  samp_cnt;
  logic [ACC_W-1:0]   acc;
  logic               pend_done;
  logic               pend_abort;
  logic               fresh_red;
  logic               fresh_ir;

  logic strobe;
  logic abort;

  assign strobe = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign abort  = chan_ir ? (!bus.IR_laser  || bus.red_laser)
                          : (!bus.red_laser || bus.IR_laser);

  // NOTE: all state here is sequential and uses non-blocking assignments, so every
  // branch below reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      chan_ir        <= 1'b0;
      div_cnt        <= '0;
      settle_cnt     <= '0;
      samp_cnt       <= '0;
      acc            <= '0;
      pend_done      <= 1'b0;
      pend_abort     <= 1'b0;
      fresh_red      <= 1'b0;
      fresh_ir       <= 1'b0;
      bus.red_avg    <= '0;
      bus.ir_avg     <= '0;
      bus.red_valid  <= 1'b0;
      bus.ir_valid   <= 1'b0;
      bus.pair_valid <= 1'b0;
      bus.err_short  <= 1'b0;
      bus.err_both   <= 1'b0;
    end else begin
      bus.red_valid  <= 1'b0;
      bus.ir_valid   <= 1'b0;
      bus.pair_valid <= 1'b0;
      bus.err_short  <= 1'b0;
      bus.err_both   <= 1'b0;
      pend_done      <= 1'b0;
      pend_abort     <= 1'b0;

      // Publish one cycle after the final strobe; acc still holds the full window sum.
      if (pend_done) begin
        if (chan_ir) begin
          bus.ir_avg   <= acc[AVG_LOG2 +: ADC_WIDTH];
          bus.ir_valid <= 1'b1;
          if (fresh_red) begin
            bus.pair_valid <= 1'b1;
            fresh_red      <= 1'b0;
            fresh_ir       <= 1'b0;
          end else begin
            fresh_ir <= 1'b1;
          end
        end else begin
          bus.red_avg   <= acc[AVG_LOG2 +: ADC_WIDTH];
          bus.red_valid <= 1'b1;
          if (fresh_ir) begin
            bus.pair_valid <= 1'b1;
            fresh_red      <= 1'b0;
            fresh_ir       <= 1'b0;
          end else begin
            fresh_red <= 1'b1;
          end
        end
      end

      if (pend_abort) begin
        bus.err_short <= 1'b1;
        if (chan_ir) fresh_ir  <= 1'b0;
        else         fresh_red <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.red_laser && bus.IR_laser) begin
            bus.err_both <= 1'b1;
            state        <= HOLD;
          end else if (bus.red_laser || bus.IR_laser) begin
            chan_ir    <= bus.IR_laser;
            div_cnt    <= '0;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            acc        <= '0;
            state      <= (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;
          end
        end

        SETTLE, ACCUM: begin
          // A dropped window wins over a coincident strobe; that sample is discarded.
          if (abort) begin
            pend_abort <= 1'b1;
            state      <= HOLD;
          end else begin
            div_cnt <= strobe ? '0 : div_cnt + 1'b1;
            if (strobe) begin
              if (state == SETTLE) begin
                if (settle_cnt == SET_W'(SETTLE_LAST)) begin
                  samp_cnt <= '0;
                  state    <= ACCUM;
                end else begin
                  settle_cnt <= settle_cnt + 1'b1;
                end
              end else begin
                acc <= acc + ACC_W'(bus.adc_data);
                if (samp_cnt == SAMP_W'(SAMP_LAST)) begin
                  pend_done <= 1'b1;
                  state     <= HOLD;
                end else begin
                  samp_cnt <= samp_cnt + 1'b1;
                end
              end
            end
          end
        end

        HOLD: begin
          if (!bus.red_laser && !bus.IR_laser) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_sample_avg.sv
// Directed bench for laser_sample_avg with SAMPLE_DIV=4, SETTLE_SAMPLES=2, AVG_LOG2=2:
// window-start edge is k=0, accumulate strobes fall on k=12,16,20,24 and the valid on k=25.
module tb_laser_sample_avg;

  logic clk = 1'b0;
  logic rst = 1'b1;

  laser_sample_avg_if #(.ADC_WIDTH(8)) bus ();

  laser_sample_avg #(
    .ADC_WIDTH      (8),
    .SAMPLE_DIV     (4),
    .SETTLE_SAMPLES (2),
    .AVG_LOG2       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Pulse counts and first-seen edge index from the most recent window.
  int n_rv, n_iv, n_pv, n_es, n_eb;
  int k_rv, k_iv, k_pv, k_es, k_eb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".red_avg"},    32'(bus.red_avg),    32'h0);
    check({tag, ".ir_avg"},     32'(bus.ir_avg),     32'h0);
    check({tag, ".red_valid"},  32'(bus.red_valid),  32'h0);
    check({tag, ".ir_valid"},   32'(bus.ir_valid),   32'h0);
    check({tag, ".pair_valid"}, 32'(bus.pair_valid), 32'h0);
    check({tag, ".err_short"},  32'(bus.err_short),  32'h0);
    check({tag, ".err_both"},   32'(bus.err_both),   32'h0);
  endtask

  // Each laser is seen high on edges k=0..len-1; s0..s3 are the accumulate-strobe samples.
  task automatic run_window(input int red_len, input int ir_len,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3,
                            input int total);
    n_rv = 0; n_iv = 0; n_pv = 0; n_es = 0; n_eb = 0;
    k_rv = -1; k_iv = -1; k_pv = -1; k_es = -1; k_eb = -1;
    bus.red_laser = (red_len > 0);
    bus.IR_laser  = (ir_len > 0);
    bus.adc_data  = s0;
    for (int k = 0; k < total; k++) begin
      step();
      if (bus.red_valid)  begin n_rv++; if (k_rv < 0) k_rv = k; end
      if (bus.ir_valid)   begin n_iv++; if (k_iv < 0) k_iv = k; end
      if (bus.pair_valid) begin n_pv++; if (k_pv < 0) k_pv = k; end
      if (bus.err_short)  begin n_es++; if (k_es < 0) k_es = k; end
      if (bus.err_both)   begin n_eb++; if (k_eb < 0) k_eb = k; end
      case (k)
        11: bus.adc_data = s0;
        15: bus.adc_data = s1;
        19: bus.adc_data = s2;
        23: bus.adc_data = s3;
        default: ;
      endcase
      if (k == red_len - 1) bus.red_laser = 1'b0;
      if (k == ir_len - 1)  bus.IR_laser  = 1'b0;
    end
  endtask

  initial begin
    bus.red_laser = 1'b0;
    bus.IR_laser  = 1'b0;
    bus.adc_data  = 8'h00;

    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) step();

    // IR window, constant 0x50.
    run_window(0, 40, 8'h50, 8'h50, 8'h50, 8'h50, 45);
    check("ir1.n_valid",   32'(n_iv),       32'd1);
    check("ir1.k_valid",   32'(k_iv),       32'd25);
    check("ir1.ir_avg",    32'(bus.ir_avg), 32'h50);
    check("ir1.n_red",     32'(n_rv),       32'd0);
    check("ir1.n_pair",    32'(n_pv),       32'd0);
    check("ir1.n_short",   32'(n_es),       32'd0);

    // Red window 10,20,30,40 -> 25; IR result still fresh so the pair fires.
    run_window(40, 0, 8'd10, 8'd20, 8'd30, 8'd40, 45);
    check("red1.n_valid",  32'(n_rv),        32'd1);
    check("red1.k_valid",  32'(k_rv),        32'd25);
    check("red1.red_avg",  32'(bus.red_avg), 32'd25);
    check("red1.n_pair",   32'(n_pv),        32'd1);
    check("red1.k_pair",   32'(k_pv),        32'd25);

    // Full-scale red: no overflow; flags were cleared so no pair.
    run_window(40, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 45);
    check("red_ff.red_avg", 32'(bus.red_avg), 32'hFF);
    check("red_ff.n_valid", 32'(n_rv),        32'd1);
    check("red_ff.n_pair",  32'(n_pv),        32'd0);

    // Short IR window: drops at the first accumulate strobe.
    run_window(0, 12, 8'h11, 8'h11, 8'h11, 8'h11, 45);
    check("short.n_err",   32'(n_es),       32'd1);
    check("short.k_err",   32'(k_es),       32'd13);
    check("short.n_valid", 32'(n_iv),       32'd0);
    check("short.ir_avg",  32'(bus.ir_avg), 32'h50);

    // Next IR window averages normally and pairs with the fresh 0xFF red result.
    run_window(0, 40, 8'h30, 8'h30, 8'h30, 8'h30, 45);
    check("ir2.n_valid",   32'(n_iv),       32'd1);
    check("ir2.ir_avg",    32'(bus.ir_avg), 32'h30);
    check("ir2.n_pair",    32'(n_pv),       32'd1);
    check("ir2.n_short",   32'(n_es),       32'd0);

    // Both lasers together; IR lingers after red drops, must not start a window.
    run_window(10, 20, 8'h99, 8'h99, 8'h99, 8'h99, 45);
    check("both.n_err",    32'(n_eb),        32'd1);
    check("both.k_err",    32'(k_eb),        32'd0);
    check("both.n_short",  32'(n_es),        32'd0);
    check("both.n_red",    32'(n_rv),        32'd0);
    check("both.n_ir",     32'(n_iv),        32'd0);
    check("both.red_avg",  32'(bus.red_avg), 32'hFF);
    check("both.ir_avg",   32'(bus.ir_avg),  32'h30);

    // IR then red pairing.
    run_window(0, 40, 8'h40, 8'h40, 8'h40, 8'h40, 45);
    check("pair_ir.ir_avg",  32'(bus.ir_avg), 32'h40);
    check("pair_ir.n_pair",  32'(n_pv),       32'd0);
    run_window(40, 0, 8'h60, 8'h60, 8'h60, 8'h60, 45);
    check("pair_red.red_avg", 32'(bus.red_avg), 32'h60);
    check("pair_red.k_valid", 32'(k_rv),        32'd25);
    check("pair_red.n_pair",  32'(n_pv),        32'd1);
    check("pair_red.k_pair",  32'(k_pv),        32'd25);
    run_window(40, 0, 8'h10, 8'h10, 8'h10, 8'h10, 45);
    check("pair_clr.red_avg", 32'(bus.red_avg), 32'h10);
    check("pair_clr.n_pair",  32'(n_pv),        32'd0);

    // Reset mid-ACCUM (fresh_red is set here, so a later pair would expose a stale flag).
    bus.red_laser = 1'b1;
    bus.adc_data  = 8'h77;
    repeat (16) step();
    rst           = 1'b1;
    bus.red_laser = 1'b0;
    step();
    check_all_zero("mid_rst");
    rst = 1'b0;
    repeat (3) step();
    run_window(40, 0, 8'd4, 8'd8, 8'd12, 8'd16, 45);
    check("post_rst.red_avg", 32'(bus.red_avg), 32'd10);
    check("post_rst.n_valid", 32'(n_rv),        32'd1);
    check("post_rst.k_valid", 32'(k_rv),        32'd25);
    check("post_rst.n_pair",  32'(n_pv),        32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
